// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_ctrl
//  Purpose  : Sequencing controller for the 4-bit ALU and the split high/low
//             accumulator. Accepts one operation at a time. ADD/SUB/AND run
//             in a single EXEC cycle. MUL (shift-add) and DIV (restoring)
//             run as multi-cycle sequences.
//  Revision : 1.0 - initial release
//
//  Build option:
//    ALU_SEQ_DIV_EN  defined   -> restoring divide path (DSHIFT/DSUB/DFIN,
//                                 q_bit) is built, op_code 100 is legal.
//                    undefined -> op_code 100 is illegal, op_div tied to 0.
//
//  Ports:
//    clk             in   system clock, rising edge
//    reset_n         in   asynchronous active-low reset
//    start           in   request strobe, sampled only in IDLE
//    op_code[2:0]    in   000 ADD, 001 SUB, 010 AND, 011 MUL, 100 DIV
//    alu_lsb         in   accumulator low-half bit 0 (multiplier LSB)
//    alu_cout        in   combinational ALU carry-out (1 = no borrow)
//    carry_flag      in   registered ALU carry flag
//    op_add..op_div  out  ALU operation strobes (at most one high)
//    acc_in_select   out  high-half source, always 0 (ALU)
//    acc_high_select out  high-half mode: 00 hold, 01 shr, 10 shl, 11 load
//    acc_low_select  out  low-half mode, same encoding
//    fill_value      out  shift-in bit
//    acc_high_reset  out  clears the high half
//    busy            out  operation in progress
//    done            out  one-cycle completion pulse
//    err             out  one-cycle pulse on illegal op_code
// ============================================================================
module alu_seq_ctrl #(
  parameter int NBITS = 4,
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] op_code,
  input  logic       alu_lsb,
  input  logic       alu_cout,
  input  logic       carry_flag,
  output logic       op_add,
  output logic       op_sub,
  output logic       op_and,
  output logic       op_mul,
  output logic       op_div,
  output logic       acc_in_select,
  output logic [1:0] acc_high_select,
  output logic [1:0] acc_low_select,
  output logic       fill_value,
  output logic       acc_high_reset,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_MUL = 3'b011;
  localparam logic [2:0] c_OP_DIV = 3'b100;

  localparam logic [1:0] c_SEL_HOLD = 2'b00;
  localparam logic [1:0] c_SEL_SHR  = 2'b01;
  localparam logic [1:0] c_SEL_SHL  = 2'b10;
  localparam logic [1:0] c_SEL_LOAD = 2'b11;

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(NBITS);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_EXEC   = 4'd1,
    S_CLR    = 4'd2,
    S_MADD   = 4'd3,
    S_MSHIFT = 4'd4,
    S_DSHIFT = 4'd5,
    S_DSUB   = 4'd6,
    S_DFIN   = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_cnt_last;
  logic             w_cnt_step;
  logic             r_err;
  logic             w_legal;
  logic             w_long;
  logic             w_accept;
  logic             w_q_bit;

  // Decode of the requested operation at the IDLE sampling point.
`ifdef ALU_SEQ_DIV_EN
  assign w_legal = (op_code <= c_OP_DIV);
  assign w_long  = (op_code == c_OP_MUL) || (op_code == c_OP_DIV);
`else
  assign w_legal = (op_code <= c_OP_MUL);
  assign w_long  = (op_code == c_OP_MUL);
`endif

  assign w_accept = (r_state == S_IDLE) && start && w_legal;

  // The iteration counter is compared after its increment, so the last
  // MSHIFT/DSUB is the one that brings the count up to NBITS.
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_cnt_last = (w_cnt_inc == c_CNT_LAST);

`ifdef ALU_SEQ_DIV_EN
  assign w_cnt_step = (r_state == S_MSHIFT) || (r_state == S_DSUB);
`else
  assign w_cnt_step = (r_state == S_MSHIFT);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_op    <= 3'b000;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Illegal request: flagged for exactly one cycle, FSM stays in IDLE.
      r_err   <= (r_state == S_IDLE) && start && !w_legal;
      if (w_accept) begin
        r_op <= op_code;
      end
      if (r_state == S_CLR) begin
        r_cnt <= '0;
      end else if (w_cnt_step) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

`ifdef ALU_SEQ_DIV_EN
  // Quotient bit from the latest trial subtraction; shifted into the low
  // half on the following DSHIFT (or on DFIN for the final bit).
  logic r_q_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q_bit <= 1'b0;
    end else if (r_state == S_CLR) begin
      r_q_bit <= 1'b0;
    end else if (r_state == S_DSUB) begin
      r_q_bit <= alu_cout;
    end
  end

  assign w_q_bit = r_q_bit;
`else
  logic w_unused_cout;
  assign w_unused_cout = alu_cout;
  assign w_q_bit       = 1'b0;
`endif

  assign err = r_err;

  always_comb begin
    w_state_nxt     = r_state;
    op_add          = 1'b0;
    op_sub          = 1'b0;
    op_and          = 1'b0;
    op_mul          = 1'b0;
    op_div          = 1'b0;
    acc_in_select   = 1'b0;
    acc_high_select = c_SEL_HOLD;
    acc_low_select  = c_SEL_HOLD;
    fill_value      = 1'b0;
    acc_high_reset  = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_long ? S_CLR : S_EXEC;
        end
      end

      S_EXEC: begin
        busy            = 1'b1;
        acc_high_select = c_SEL_LOAD;
        case (r_op)
          c_OP_ADD: op_add = 1'b1;
          c_OP_SUB: op_sub = 1'b1;
          c_OP_AND: op_and = 1'b1;
          default:  ;
        endcase
        w_state_nxt = S_DONE;
      end

      S_CLR: begin
        busy           = 1'b1;
        acc_high_reset = 1'b1;
`ifdef ALU_SEQ_DIV_EN
        w_state_nxt = (r_op == c_OP_DIV) ? S_DSHIFT : S_MADD;
`else
        w_state_nxt = S_MADD;
`endif
      end

      S_MADD: begin
        busy            = 1'b1;
        op_mul          = 1'b1;
        // Partial product is accumulated only for a set multiplier bit.
        acc_high_select = alu_lsb ? c_SEL_LOAD : c_SEL_HOLD;
        w_state_nxt     = S_MSHIFT;
      end

      S_MSHIFT: begin
        busy            = 1'b1;
        acc_high_select = c_SEL_SHR;
        acc_low_select  = c_SEL_SHR;
        fill_value      = carry_flag;
        w_state_nxt     = w_cnt_last ? S_DONE : S_MADD;
      end

`ifdef ALU_SEQ_DIV_EN
      S_DSHIFT: begin
        busy            = 1'b1;
        acc_high_select = c_SEL_SHL;
        acc_low_select  = c_SEL_SHL;
        fill_value      = w_q_bit;
        w_state_nxt     = S_DSUB;
      end

      S_DSUB: begin
        busy            = 1'b1;
        op_div          = 1'b1;
        // Restoring divide: keep the difference only when it did not borrow.
        acc_high_select = alu_cout ? c_SEL_LOAD : c_SEL_HOLD;
        w_state_nxt     = w_cnt_last ? S_DFIN : S_DSHIFT;
      end

      S_DFIN: begin
        busy            = 1'b1;
        acc_low_select  = c_SEL_SHL;
        fill_value      = w_q_bit;
        w_state_nxt     = S_DONE;
      end
`endif

      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq_ctrl
//  Purpose  : Directed bench for alu_seq_ctrl. A small accumulator/ALU model
//             reacts to the controller's selects so that arithmetic results
//             can be checked along with cycle-by-cycle output patterns.
//             Build with ALU_SEQ_DIV_EN to include the divide vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [2:0] op_code;
  logic       alu_lsb;
  logic       alu_cout;
  logic       carry_flag;
  logic       op_add, op_sub, op_and, op_mul, op_div;
  logic       acc_in_select;
  logic [1:0] acc_high_select;
  logic [1:0] acc_low_select;
  logic       fill_value;
  logic       acc_high_reset;
  logic       busy;
  logic       done;
  logic       err;

  alu_seq_ctrl #(.NBITS(4), .CNT_W(3)) u_dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .op_code         (op_code),
    .alu_lsb         (alu_lsb),
    .alu_cout        (alu_cout),
    .carry_flag      (carry_flag),
    .op_add          (op_add),
    .op_sub          (op_sub),
    .op_and          (op_and),
    .op_mul          (op_mul),
    .op_div          (op_div),
    .acc_in_select   (acc_in_select),
    .acc_high_select (acc_high_select),
    .acc_low_select  (acc_low_select),
    .fill_value      (fill_value),
    .acc_high_reset  (acc_high_reset),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output word: [14]add [13]sub [12]and [11]mul [10]div [9]in_sel
  // [8:7]high_sel [6:5]low_sel [4]fill [3]high_rst [2]busy [1]done [0]err
  logic [15:0] w_outs;
  assign w_outs = {1'b0, op_add, op_sub, op_and, op_mul, op_div, acc_in_select,
                   acc_high_select, acc_low_select, fill_value, acc_high_reset,
                   busy, done, err};

  // ---------------- accumulator / ALU model ----------------
  logic [3:0] r_acc_hi, r_acc_lo, r_b;
  logic       r_carry;
  logic       pre_en;
  logic [3:0] pre_hi, pre_lo, pre_b;
  logic [4:0] w_sum;
  logic [3:0] w_alu_res;
  logic       w_alu_cout;

  assign w_sum = {1'b0, r_acc_hi} + {1'b0, r_b};

  always_comb begin
    w_alu_res  = w_sum[3:0];
    w_alu_cout = w_sum[4];
    if (op_sub || op_div) begin
      w_alu_res  = r_acc_hi - r_b;
      w_alu_cout = (r_acc_hi >= r_b);
    end else if (op_and) begin
      w_alu_res  = r_acc_hi & r_b;
      w_alu_cout = 1'b0;
    end
  end

  assign alu_cout   = w_alu_cout;
  assign alu_lsb    = r_acc_lo[0];
  assign carry_flag = r_carry;

  always @(posedge clk) begin
    if (pre_en) begin
      r_acc_hi <= pre_hi;
      r_acc_lo <= pre_lo;
      r_b      <= pre_b;
      r_carry  <= 1'b0;
    end else begin
      if (acc_high_reset) begin
        r_acc_hi <= 4'h0;
      end else begin
        case (acc_high_select)
          2'b01:   r_acc_hi <= {fill_value, r_acc_hi[3:1]};
          2'b10:   r_acc_hi <= {r_acc_hi[2:0], r_acc_lo[3]};
          2'b11:   r_acc_hi <= w_alu_res;
          default: ;
        endcase
      end
      case (acc_low_select)
        2'b01:   r_acc_lo <= {r_acc_hi[0], r_acc_lo[3:1]};
        2'b10:   r_acc_lo <= {r_acc_lo[2:0], fill_value};
        default: ;
      endcase
      if (op_add || op_sub || op_and || op_mul || op_div) begin
        r_carry <= (acc_high_select == 2'b11) ? w_alu_cout : 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] hi, input logic [3:0] lo, input logic [3:0] b);
    pre_hi = hi;
    pre_lo = lo;
    pre_b  = b;
    pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Starts at a negedge (cycle 0) and returns at the cycle-1 negedge.
  task automatic start_op(input logic [2:0] op);
    op_code = op;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // MUL D x B: per-cycle expected outputs for cycles 1..10.
  localparam logic [15:0] c_MUL_EXP [10] = '{
    16'h000C, 16'h0984, 16'h00A4, 16'h0804, 16'h00A4,
    16'h0984, 16'h00A4, 16'h0984, 16'h00B4, 16'h0002
  };

`ifdef ALU_SEQ_DIV_EN
  // DIV D / 3: per-cycle expected outputs for cycles 1..11.
  localparam logic [15:0] c_DIV_EXP [11] = '{
    16'h000C, 16'h0144, 16'h0404, 16'h0144, 16'h0584, 16'h0154,
    16'h0404, 16'h0144, 16'h0404, 16'h0044, 16'h0002
  };
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    op_code  = 3'b000;
    pre_en   = 1'b0;
    pre_hi   = 4'h0;
    pre_lo   = 4'h0;
    pre_b    = 4'h0;

    #1;
    check("reset_outs", w_outs, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_outs", w_outs, 16'h0000);

    // ADD: 5 + 6 = B
    preload(4'h5, 4'h0, 4'h6);
    start_op(3'b000);
    check("add_c1", w_outs, 16'h4184);
    @(negedge clk);
    check("add_c2_done", w_outs, 16'h0002);
    check("add_hi", 16'(r_acc_hi), 16'h000B);
    @(negedge clk);
    check("add_c3_idle", w_outs, 16'h0000);

    // SUB: 9 - 4 = 5, AND: C & A = 8
    preload(4'h9, 4'h0, 4'h4);
    start_op(3'b001);
    check("sub_c1", w_outs, 16'h2184);
    @(negedge clk);
    check("sub_hi", 16'(r_acc_hi), 16'h0005);
    preload(4'hC, 4'h0, 4'hA);
    start_op(3'b010);
    check("and_c1", w_outs, 16'h1184);
    @(negedge clk);
    check("and_hi", 16'(r_acc_hi), 16'h0008);

    // MUL: D x B = 8F
    preload(4'h7, 4'hD, 4'hB);
    start_op(3'b011);
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("mul_c%0d", c), w_outs, c_MUL_EXP[c-1]);
      if (c < 10) @(negedge clk);
    end
    check("mul_product", 16'({r_acc_hi, r_acc_lo}), 16'h008F);
    @(negedge clk);
    check("mul_c11_idle", w_outs, 16'h0000);

    // Illegal op_code 110
    start_op(3'b110);
    check("ill110_c1", w_outs, 16'h0001);
    @(negedge clk);
    check("ill110_c2", w_outs, 16'h0000);

`ifdef ALU_SEQ_DIV_EN
    // DIV: D / 3 = 4 remainder 1
    preload(4'h0, 4'hD, 4'h3);
    start_op(3'b100);
    for (int c = 1; c <= 11; c++) begin
      check($sformatf("div_c%0d", c), w_outs, c_DIV_EXP[c-1]);
      if (c < 11) @(negedge clk);
    end
    check("div_quot", 16'(r_acc_lo), 16'h0004);
    check("div_rem", 16'(r_acc_hi), 16'h0001);
    @(negedge clk);

    // DIV by zero: quotient F, remainder = dividend
    preload(4'h0, 4'hD, 4'h0);
    start_op(3'b100);
    begin
      int cyc;
      cyc = 1;
      while (!done && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      check("div0_latency", 16'(cyc), 16'd11);
    end
    check("div0_quot", 16'(r_acc_lo), 16'h000F);
    check("div0_rem", 16'(r_acc_hi), 16'h000D);
    @(negedge clk);
`else
    // Without the divide path, op_code 100 is illegal
    start_op(3'b100);
    check("ill100_c1", w_outs, 16'h0001);
    @(negedge clk);
    check("ill100_c2", w_outs, 16'h0000);
`endif

    // Held start during MUL, op_code changed mid-run, re-strobe at cycle 4
    preload(4'h0, 4'h3, 4'h2);
    op_code = 3'b011;
    start   = 1'b1;
    @(negedge clk);                       // cycle 1
    op_code = 3'b000;
    @(negedge clk);                       // cycle 2
    check("held_c2_mul", 16'({op_add, op_mul}), 16'h0001);
    @(negedge clk);                       // cycle 3
    start = 1'b0;
    @(negedge clk);                       // cycle 4
    start = 1'b1;
    repeat (6) @(negedge clk);            // cycle 10
    check("held_c10_done", w_outs, 16'h0002);
    @(negedge clk);                       // cycle 11
    check("held_c11_idle", w_outs, 16'h0000);
    @(negedge clk);                       // cycle 12
    start = 1'b0;
    check("held_c12_add", w_outs, 16'h4184);
    @(negedge clk);                       // cycle 13
    check("held_c13_done", w_outs, 16'h0002);
    @(negedge clk);

    // Async reset in the middle of a MUL
    preload(4'h0, 4'hD, 4'hB);
    start_op(3'b011);
    repeat (4) @(negedge clk);            // cycle 5
    check("rst_c5_pre", w_outs, 16'h00A4);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_outs", w_outs, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_after_idle", w_outs, 16'h0000);
    preload(4'h5, 4'h0, 4'h6);
    start_op(3'b000);
    check("rst_add_c1", w_outs, 16'h4184);
    @(negedge clk);
    check("rst_add_c2", w_outs, 16'h0002);
    check("rst_add_hi", 16'(r_acc_hi), 16'h000B);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
